// File: rtl/sobel_window_buffer.sv
// Sobel front end: raster pixel stream in, 3x3 interior windows out via two line buffers.
// All outputs are registered; windows spanning a row wrap are never flagged.
module sobel_window_buffer #(
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 frame_start,
    input  logic                 pixel_valid,
    input  logic [7:0]           pixel_in,
    output logic [0:8][7:0]      windowBuffer,
    output logic                 start_calculations,
    output logic [RW-1:0]        centre_row,
    output logic [CW-1:0]        centre_col,
    output logic                 frame_done
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, acc_row;
    logic [CW-1:0] col_q, acc_col;
    logic          start, accept, last, win_vld;
    logic [7:0]    up1_rd, up2_rd;
    logic [7:0]    lb_up1 [IMG_WIDTH];
    logic [7:0]    lb_up2 [IMG_WIDTH];

    assign start = frame_start & pixel_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = ACTIVE;
            ACTIVE: begin
                if (start)                   state_d = ACTIVE;
                else if (pixel_valid && last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A frame_start pixel is always (0,0), whatever the counters hold.
    always_comb begin
        accept  = start | (pixel_valid & (state_q == ACTIVE));
        acc_row = start ? '0 : row_q;
        acc_col = start ? '0 : col_q;
        last    = (acc_row == ROW_LAST) && (acc_col == COL_LAST);
        win_vld = accept && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
        up1_rd  = lb_up1[acc_col];
        up2_rd  = lb_up2[acc_col];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (last) begin
                row_q <= '0;
                col_q <= '0;
            end else if (acc_col == COL_LAST) begin
                row_q <= acc_row + RW'(1);
                col_q <= '0;
            end else begin
                row_q <= acc_row;
                col_q <= acc_col + CW'(1);
            end
        end
    end

    // Line buffers carry no reset; nonblocking writes give read-before-write.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_up2[acc_col] <= up1_rd;
            lb_up1[acc_col] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            windowBuffer       <= '0;
            start_calculations <= 1'b0;
            centre_row         <= '0;
            centre_col         <= '0;
            frame_done         <= 1'b0;
        end else begin
            start_calculations <= win_vld;
            frame_done         <= accept & last;
            if (accept) begin
                windowBuffer[0] <= windowBuffer[1];
                windowBuffer[1] <= windowBuffer[2];
                windowBuffer[2] <= up2_rd;
                windowBuffer[3] <= windowBuffer[4];
                windowBuffer[4] <= windowBuffer[5];
                windowBuffer[5] <= up1_rd;
                windowBuffer[6] <= windowBuffer[7];
                windowBuffer[7] <= windowBuffer[8];
                windowBuffer[8] <= pixel_in;
            end
            if (win_vld) begin
                centre_row <= acc_row - RW'(1);
                centre_col <= acc_col - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 image.
module tb_sobel_window_buffer;
    logic            clk, n_rst, frame_start, pixel_valid;
    logic [7:0]      pixel_in;
    logic [0:8][7:0] windowBuffer;
    logic            start_calculations, frame_done;
    logic [1:0]      centre_row, centre_col;
    int              checks = 0;
    int              errors = 0;
    int              strobes;

    sobel_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .windowBuffer(windowBuffer), .start_calculations(start_calculations),
        .centre_row(centre_row), .centre_col(centre_col), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Image model: mode 0 is base+16r+c, mode 1 is a 0x00/0xFF checkerboard.
    function automatic logic [7:0] pix(input logic [7:0] base, input int mode, input int r, input int c);
        if (mode != 0) return ((r + c) % 2) ? 8'hFF : 8'h00;
        return base + 8'(16 * r + c);
    endfunction

    task automatic cyc(input logic fs, input logic pv, input logic [7:0] px);
        frame_start = fs;
        pixel_valid = pv;
        pixel_in    = px;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
    endtask

    // Feed the first npix pixels of a frame, each followed by gaps idle cycles.
    task automatic run_frame(input logic [7:0] base, input int mode, input int npix,
                             input logic fs_first, input int gaps);
        logic [0:8][7:0] ew;
        for (int k = 0; k < npix; k++) begin
            int r, c;
            r = k / 4;
            c = k % 4;
            cyc(fs_first && k == 0, 1'b1, pix(base, mode, r, c));
            chk($sformatf("strobe r%0d c%0d", r, c), 72'(start_calculations), 72'(r >= 2 && c >= 2));
            chk($sformatf("done r%0d c%0d", r, c), 72'(frame_done), 72'(r == 3 && c == 3));
            if (r >= 2 && c >= 2) begin
                strobes++;
                for (int i = 0; i < 9; i++) ew[i] = pix(base, mode, r - 2 + i / 3, c - 2 + i % 3);
                chk($sformatf("win r%0d c%0d", r, c), windowBuffer, ew);
                chk("centre_row", 72'(centre_row), 72'(r - 1));
                chk("centre_col", 72'(centre_col), 72'(c - 1));
            end
            for (int g = 0; g < gaps; g++) begin
                cyc(1'b0, 1'b0, 8'hEE);
                chk("gap strobe", 72'(start_calculations), 72'(0));
                chk("gap done", 72'(frame_done), 72'(0));
            end
        end
    endtask

    initial begin
        n_rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_in = 8'h00;
        #2 n_rst = 1'b0;
        #1;
        chk("reset win", windowBuffer, 72'(0));
        chk("reset strobe", 72'(start_calculations), 72'(0));
        chk("reset done", 72'(frame_done), 72'(0));
        chk("reset centre", 72'({centre_row, centre_col}), 72'(0));
        @(negedge clk) n_rst = 1'b1;

        // pixel_valid alone in IDLE accepts nothing
        cyc(1'b0, 1'b1, 8'h33);
        chk("idle no strobe", 72'(start_calculations), 72'(0));

        strobes = 0;
        run_frame(8'h00, 0, 16, 1'b1, 0);
        chk("basic strobes", 72'(strobes), 72'(4));

        strobes = 0;
        run_frame(8'h00, 0, 16, 1'b1, 2);
        chk("bubble strobes", 72'(strobes), 72'(4));

        // stray 17th pixel without frame_start lands in DONE
        cyc(1'b0, 1'b1, 8'h55);
        chk("stray strobe", 72'(start_calculations), 72'(0));
        chk("stray done", 72'(frame_done), 72'(0));
        strobes = 0;
        run_frame(8'h80, 0, 16, 1'b1, 0);
        chk("second frame strobes", 72'(strobes), 72'(4));

        // abort after 9 pixels, then a full frame from a new frame_start
        run_frame(8'h20, 0, 9, 1'b1, 0);
        strobes = 0;
        run_frame(8'h40, 0, 16, 1'b1, 0);
        chk("restart strobes", 72'(strobes), 72'(4));

        // async reset right after the first strobe of a frame
        run_frame(8'h00, 0, 11, 1'b1, 0);
        #2 n_rst = 1'b0;
        #1;
        chk("async win", windowBuffer, 72'(0));
        chk("async strobe", 72'(start_calculations), 72'(0));
        chk("async centre", 72'({centre_row, centre_col}), 72'(0));
        chk("async done", 72'(frame_done), 72'(0));
        #2 n_rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b1, 8'(k));
            chk("post-reset no start", 72'(start_calculations), 72'(0));
        end
        strobes = 0;
        run_frame(8'h00, 0, 16, 1'b1, 0);
        chk("post-reset strobes", 72'(strobes), 72'(4));

        strobes = 0;
        run_frame(8'h00, 1, 16, 1'b1, 1);
        chk("checker strobes", 72'(strobes), 72'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Upstream stage of the Sobel datapath. Accepts a raster-order 8-bit grayscale pixel stream, holds the two previous image rows in line buffers, and assembles a 3x3 neighbourhood window. It presents the window as `windowBuffer[0:8]` together with a one-cycle `start_calculations` strobe, and these outputs drive the horizontal and vertical gradient blocks directly. Windows are produced only for interior pixels; the block does no border padding.

## Interface
- `IMG_WIDTH`, 640, pixels per row, minimum 3
- `IMG_HEIGHT`, 480, rows per frame, minimum 3
- `clk`  in  1  single system clock, rising edge
- `n_rst`  in  1  reset, asynchronous, active-low
- `frame_start`  in  1  marks the first pixel of a frame; acts as a restart from any state
- `pixel_valid`  in  1  `pixel_in` is valid this cycle
- `pixel_in`  in  8  grayscale pixel, unsigned
- `windowBuffer[0:8]`  out  9x8  3x3 window, row-major: `P0..P2` top row, `P3..P5` middle row, `P6..P8` bottom row; within each row, left to right
- `start_calculations`  out  1  one-cycle strobe; `windowBuffer` is a new valid window
- `centre_row`  out  `$clog2(IMG_HEIGHT)`  image row of the window centre (`P4`)
- `centre_col`  out  `$clog2(IMG_WIDTH)`  image column of the window centre
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- **State machine** (`IDLE`, `ACTIVE`, `DONE`):
  - `IDLE`: waits for `frame_start & pixel_valid`. That pixel is accepted as (0,0) and the state goes to `ACTIVE`.
  - `ACTIVE`: each `pixel_valid` cycle accepts one pixel at (`row`, `col`).
    - `col` wraps from `IMG_WIDTH-1` to 0 and then increments `row`.
    - Accepting (`IMG_HEIGHT-1`, `IMG_WIDTH-1`) moves the state to `DONE`.
  - `DONE`: `pixel_valid` is ignored. `frame_start & pixel_valid` restarts as described for `IDLE`.
  - `frame_start & pixel_valid` in `ACTIVE` aborts the current frame: the counters restart and that pixel is (0,0). No `frame_done` is raised for the aborted frame.
  - `frame_start` without `pixel_valid` has no effect.
- **Line buffers:** two arrays of `IMG_WIDTH` x 8 bits.
  - `lb_up1[c]` holds row `row-1`; `lb_up2[c]` holds row `row-2`.
  - On an accepted pixel at column `c`: read `lb_up2[c]` and `lb_up1[c]`, then write `lb_up2[c] <= lb_up1[c]` and `lb_up1[c] <= pixel_in`.
  - Read-before-write within the same cycle is required.
  - Line-buffer contents are not reset.
- **Window shift,** on each accepted pixel only:
  - `P0<=P1`, `P1<=P2`, `P2<=lb_up2[c]`
  - `P3<=P4`, `P4<=P5`, `P5<=lb_up1[c]`
  - `P6<=P7`, `P7<=P8`, `P8<=pixel_in`
  - Result: `P8` is (`row`, `col`) and `P0` is (`row-2`, `col-2`).
- **Window valid** when the accepted pixel has `row>=2` and `col>=2`. On that cycle:
  - `start_calculations` is registered high.
  - `centre_row <= row-1` and `centre_col <= col-1`.
  - Windows that span a row wrap (`col<2`) are never flagged. Stale line-buffer data is therefore never exposed.
- Each frame yields exactly (`IMG_WIDTH-2`)*(`IMG_HEIGHT-2`) strobes.
- **Cycles without `pixel_valid`:** window registers, counters and centre outputs hold. `start_calculations` is 0.

## Timing
- **Reset values:**
  - `windowBuffer` all 0x00, `start_calculations` 0, `frame_done` 0, `centre_row` 0, `centre_col` 0.
  - State `IDLE`, `row` 0, `col` 0.
- **Latency:** the pixel that completes a window is accepted on edge N. `windowBuffer`, `start_calculations` and the centre outputs are valid after edge N and until edge N+1.
- Outputs are fully registered; there is no combinational path from any input to any output.
- **Throughput:** one pixel per cycle sustained, with no backpressure. Gaps in `pixel_valid` are arbitrary.
- `frame_done` is high for exactly the cycle following acceptance of the last pixel. It coincides with the final `start_calculations`.
- **Mid-operation reset:** `n_rst` low clears all state asynchronously and immediately; all outputs go to their reset values in the same cycle. The next frame requires `frame_start`.

## Test plan
- **Basic 4x4 frame:** `IMG_WIDTH=4`, `IMG_HEIGHT=4`, pixel (r,c)=16r+c, `pixel_valid` continuous.
  - Exactly 4 strobes, with centres (1,1), (1,2), (2,1), (2,2).
  - First window is `00,01,02,10,11,12,20,21,22`.
  - Last window is `11,12,13,21,22,23,31,32,33`.
  - `frame_done` is coincident with the fourth strobe.
- **Bubbles:** same frame with `pixel_valid` toggling 1,0,0,1,... → identical window and centre sequence. `start_calculations` is never high on a cycle that follows a non-accepting edge.
- **Frame boundary:** 17 valid pixels where pixel 16 has `frame_start=0`. Then a new frame `frame_start` with values +0x80 → the stray pixel is ignored in `DONE`. The second frame's first window is `80,81,82,90,91,92,A0,A1,A2`.
- **Restart mid-frame:** `frame_start` on pixel 9 of frame 1 → no `frame_done` for frame 1. The new frame's first strobe occurs 11 accepted pixels later, centre (1,1).
- **Async reset mid-frame:** `n_rst` pulsed low between clock edges during row 2 → all outputs 0 immediately. `pixel_valid` without `frame_start` produces no strobes. A full frame after `frame_start` reproduces the basic 4x4 frame results.
- **Extremes:** pixels alternating 0x00/0xFF; default parameters 640x480 → 638*478=304964 strobes. The last centre is (478,638).
